// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_DATA, START, DATA, PARITY, STOP
  } uart_tx_state_t;

  // Cycles WAIT_DATA waits for the FIFO read pulse before giving up.
  localparam int WAIT_DATA_TIMEOUT = 2;

  // Zero-extended words do not change the XOR, so a fixed 32-bit input covers DATA_BITS <= 32.
  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the terminal cycle.
module baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_bit_done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_done = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= '0;
    else if (i_clear || o_bit_done)  r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the TX FIFO and serializes them as UART frames on o_tx.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_fifo_empty,
  input  logic                 i_fifo_ready_pulse,
  input  logic [DATA_BITS-1:0] i_fifo_rd_data,
  output logic                 o_fifo_rd_en,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done_pulse
);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  uart_tx_state_t       r_state, w_next_state;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [1:0]           r_wait;
  logic                 w_bit_done;
  logic                 w_baud_clear;
  logic                 w_last_data;
  logic                 w_last_stop;

  // Bit timing only runs while a frame is on the wire.
  assign w_baud_clear = (r_state == IDLE) || (r_state == FETCH) || (r_state == WAIT_DATA);
  assign w_last_data  = (r_bit_idx == BIT_W'(DATA_BITS - 1));
  assign w_last_stop  = (r_bit_idx == BIT_W'(STOP_BITS - 1));

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_baud_clear),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (i_enable && !i_fifo_empty) w_next_state = FETCH;
      FETCH:     w_next_state = WAIT_DATA;
      // A stale empty flag can send us here with nothing to read; give up after the timeout.
      WAIT_DATA: if (i_fifo_ready_pulse)                           w_next_state = START;
                 else if (r_wait == 2'(WAIT_DATA_TIMEOUT - 1))     w_next_state = IDLE;
      START:     if (w_bit_done) w_next_state = DATA;
      DATA:      if (w_bit_done && w_last_data) w_next_state = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:    if (w_bit_done) w_next_state = STOP;
      STOP:      if (w_bit_done && w_last_stop) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_tx         = 1'b1;
    o_fifo_rd_en = (r_state == FETCH);
    o_busy       = (r_state != IDLE);
    o_done_pulse = (r_state == STOP) && w_bit_done && w_last_stop;
    case (r_state)
      START:   o_tx = 1'b0;
      DATA:    o_tx = r_shift[0];
      PARITY:  o_tx = r_par;
      default: o_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_idx <= '0;
      r_wait    <= '0;
    end else begin
      r_wait <= (r_state == WAIT_DATA) ? r_wait + 2'd1 : 2'd0;
      if (r_state == WAIT_DATA && i_fifo_ready_pulse) begin
        r_shift <= i_fifo_rd_data;
        r_par   <= calc_parity(32'(i_fifo_rd_data), PARITY_ODD != 0);
      end else if (r_state == DATA && w_bit_done) begin
        r_shift <= r_shift >> 1;
      end
      // Index restarts on every state change, so it serves both data and stop bits.
      if (w_next_state != r_state) r_bit_idx <= '0;
      else if (w_bit_done)         r_bit_idx <= r_bit_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: main DUT (no parity) plus even/odd parity DUTs, each fed by a FIFO model.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic fake_ne = 1'b0;

  // main DUT signals and FIFO model
  logic       m_empty, m_empty_r = 1'b1, m_ready = 1'b0, m_rd_en, m_tx, m_busy, m_done;
  logic [7:0] m_data = 8'h00;
  logic [7:0] mq [0:15];
  int         mw = 0, mr = 0, m_rd_cnt = 0;
  logic       m_rd_prev = 1'b0, m_dbl = 1'b0;

  // parity DUTs share one FIFO model
  logic       p_empty_r = 1'b1, p_ready = 1'b0, pe_rd_en, po_rd_en;
  logic       pe_tx, po_tx, pe_busy, po_busy, pe_done, po_done;
  logic [7:0] p_data = 8'h00;
  logic [7:0] pq [0:15];
  int         pw = 0, pr = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int base;

  always #5 clk = ~clk;

  assign m_empty = m_empty_r & ~fake_ne;

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_fifo_empty(m_empty),
    .i_fifo_ready_pulse(m_ready), .i_fifo_rd_data(m_data), .o_fifo_rd_en(m_rd_en),
    .o_tx(m_tx), .o_busy(m_busy), .o_done_pulse(m_done));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_fifo_empty(p_empty_r),
    .i_fifo_ready_pulse(p_ready), .i_fifo_rd_data(p_data), .o_fifo_rd_en(pe_rd_en),
    .o_tx(pe_tx), .o_busy(pe_busy), .o_done_pulse(pe_done));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_fifo_empty(p_empty_r),
    .i_fifo_ready_pulse(p_ready), .i_fifo_rd_data(p_data), .o_fifo_rd_en(po_rd_en),
    .o_tx(po_tx), .o_busy(po_busy), .o_done_pulse(po_done));

  // FIFO model: 1-cycle read latency, empty flag registered from pre-pop occupancy
  always @(posedge clk) begin
    m_empty_r <= (mw == mr);
    m_ready   <= 1'b0;
    if (m_rd_en && mw != mr) begin
      m_data  <= mq[mr];
      m_ready <= 1'b1;
      mr      <= mr + 1;
    end
    if (m_rd_en) m_rd_cnt <= m_rd_cnt + 1;
    if (m_rd_en && m_rd_prev) m_dbl <= 1'b1;
    m_rd_prev <= m_rd_en;
  end

  always @(posedge clk) begin
    p_empty_r <= (pw == pr);
    p_ready   <= 1'b0;
    if (pe_rd_en && pw != pr) begin
      p_data  <= pq[pr];
      p_ready <= 1'b1;
      pr      <= pr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic cur_tx(input int w);
    return (w == 0) ? m_tx : pe_tx;
  endfunction

  task automatic wait_fall(input string tag, input int which);
    int n;
    n = 0;
    while (cur_tx(which) !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " start_seen"}, int'(n < 400), 1);
  endtask

  // Checks every cycle of one frame from the falling edge; ends on the last stop-bit cycle.
  task automatic frame(input logic [7:0] d, input int mode, input int drop_en_at, input string tag);
    int nb;
    nb = (mode != 0) ? 11 : 10;
    wait_fall(tag, mode);
    for (int i = 0; i < 4 * nb; i++) begin
      int   k;
      logic eb, ep, eo, ed;
      k  = i / 4;
      eb = 1'b1;
      if (k == 0)      eb = 1'b0;
      else if (k <= 8) eb = d[k-1];
      ep = eb;
      eo = eb;
      if (mode != 0 && k == 9) begin
        ep = ^d;
        eo = ~^d;
      end
      ed = (i == 4 * nb - 1);
      if (i == drop_en_at) en = 1'b0;
      if (mode == 0) begin
        chk1($sformatf("%s tx[%0d]", tag, i), m_tx, eb);
        chk1($sformatf("%s done[%0d]", tag, i), m_done, ed);
      end else begin
        chk1($sformatf("%s even_tx[%0d]", tag, i), pe_tx, ep);
        chk1($sformatf("%s odd_tx[%0d]", tag, i), po_tx, eo);
        chk1($sformatf("%s even_done[%0d]", tag, i), pe_done, ed);
        chk1($sformatf("%s odd_done[%0d]", tag, i), po_done, ed);
      end
      if (i != 4 * nb - 1) @(negedge clk);
    end
  endtask

  // Counts high cycles between the last stop cycle and the next start bit.
  task automatic gap(input string tag, input int which);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cur_tx(which) !== 1'b0 && n < 50);
    chk({tag, " idle_gap"}, n - 1, 3);
  endtask

  initial begin
    // 1. reset
    repeat (3) @(negedge clk);
    chk1("rst tx", m_tx, 1'b1);
    chk1("rst rd_en", m_rd_en, 1'b0);
    chk1("rst busy", m_busy, 1'b0);
    chk1("rst done", m_done, 1'b0);
    chk1("rst par_tx", pe_tx, 1'b1);
    rst_n = 1'b1;
    en    = 1'b1;
    base  = m_rd_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk1("idle tx", m_tx, 1'b1);
      chk1("idle busy", m_busy, 1'b0);
    end
    chk("idle rd_en count", m_rd_cnt - base, 0);

    // 2. single frame 0xA5
    base = m_rd_cnt;
    mq[mw] = 8'hA5; mw++;
    frame(8'hA5, 0, -1, "t2");
    chk("t2 rd_en count", m_rd_cnt - base, 1);
    @(negedge clk);
    chk1("t2 idle busy", m_busy, 1'b0);
    chk1("t2 idle tx", m_tx, 1'b1);

    // 3. parity: even/odd instances each send 0xA5 then 0x07
    pq[pw] = 8'hA5; pw++;
    pq[pw] = 8'h07; pw++;
    frame(8'hA5, 1, -1, "t3a");
    gap("t3", 1);
    frame(8'h07, 1, -1, "t3b");

    // 4. back-to-back
    repeat (3) @(negedge clk);
    base = m_rd_cnt;
    mq[mw] = 8'h00; mw++;
    mq[mw] = 8'hFF; mw++;
    mq[mw] = 8'h3C; mw++;
    frame(8'h00, 0, -1, "t4a");
    gap("t4ab", 0);
    frame(8'hFF, 0, -1, "t4b");
    gap("t4bc", 0);
    frame(8'h3C, 0, -1, "t4c");
    repeat (5) @(negedge clk);
    chk("t4 rd_en count", m_rd_cnt - base, 3);
    chk1("t4 idle busy", m_busy, 1'b0);

    // 5. stale empty flag: one pop request, no data, back to idle
    base = m_rd_cnt;
    fake_ne = 1'b1;
    @(negedge clk);
    chk1("t5 fetch rd_en", m_rd_en, 1'b1);
    fake_ne = 1'b0;
    @(negedge clk);
    chk1("t5 wait1 rd_en", m_rd_en, 1'b0);
    chk1("t5 wait1 busy", m_busy, 1'b1);
    chk1("t5 wait1 tx", m_tx, 1'b1);
    @(negedge clk);
    chk1("t5 wait2 busy", m_busy, 1'b1);
    @(negedge clk);
    chk1("t5 idle busy", m_busy, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk1("t5 tx high", m_tx, 1'b1);
      chk1("t5 no done", m_done, 1'b0);
      @(negedge clk);
    end
    chk("t5 rd_en count", m_rd_cnt - base, 1);

    // 6a. drop enable mid-DATA: frame completes, no further fetch
    base = m_rd_cnt;
    mq[mw] = 8'h5A; mw++;
    mq[mw] = 8'h81; mw++;
    frame(8'h5A, 0, 10, "t6a");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk1("t6a tx high", m_tx, 1'b1);
      chk1("t6a busy", m_busy, 1'b0);
    end
    chk("t6a rd_en count", m_rd_cnt - base, 1);

    // 6b. reset mid-DATA while sending 0x81, then next word intact
    en = 1'b1;
    wait_fall("t6b", 0);
    repeat (13) @(negedge clk);
    chk1("t6b pre-reset tx", m_tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("t6b reset tx", m_tx, 1'b1);
    chk1("t6b reset busy", m_busy, 1'b0);
    chk1("t6b reset rd_en", m_rd_en, 1'b0);
    mq[mw] = 8'hC3; mw++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frame(8'hC3, 0, -1, "t6c");
    @(negedge clk);
    chk1("t6c idle busy", m_busy, 1'b0);

    chk1("rd_en never consecutive", m_dbl, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
